// File: rtl/secuenciador_iir_2canales.sv
// Two-channel sequencer for a shared direct-form-II biquad MAC datapath.
// Latches per-channel sample flags, arbitrates round-robin on ties and
// steps the datapath through the five MAC operations of one sample.
module secuenciador_iir_2canales #(
    parameter int STEP_CYC = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Bandera_ADC0,
    input  logic       Bandera_ADC1,
    output logic [2:0] sel_const,
    output logic       banco,
    output logic [1:0] sel_fun,
    output logic [1:0] sel_acum,
    output logic       acum_en,
    output logic       Senal,
    output logic       Band_Listo,
    output logic       ocupado,
    output logic [1:0] sobrecarga
);

    localparam int CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S_A1 = 3'd1,
        S_A2 = 3'd2,
        S_B0 = 3'd3,
        S_B1 = 3'd4,
        S_B2 = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t          state, state_nxt;
    logic   [CW-1:0] cnt, cnt_nxt;
    logic   [1:0]    pend, pend_nxt;
    logic            rr;
    logic   [1:0]    pulse;
    logic            can_grant;
    logic            gch;
    logic   [1:0]    gmask;
    logic   [1:0]    ovr;
    logic            last;
    logic            last_nxt;
    logic            step_nxt;
    logic   [2:0]    sc_nxt;
    logic   [1:0]    sf_nxt;
    logic   [1:0]    sa_nxt;

    // Arbitration, pending-flag update and next-state/next-output decode
    always_comb begin
        pulse     = {Bandera_ADC1, Bandera_ADC0};
        can_grant = ((state == IDLE) || (state == DONE)) && (pend != 2'b00);
        gch       = (pend == 2'b11) ? rr : pend[1];
        gmask     = can_grant ? (gch ? 2'b10 : 2'b01) : 2'b00;
        // A pulse landing on the grant edge of its own channel re-queues it
        pend_nxt  = (pend & ~gmask) | pulse;
        ovr       = pulse & pend & ~gmask;
        last      = (cnt == CW'(STEP_CYC - 1));

        state_nxt = IDLE;
        cnt_nxt   = '0;
        case (state)
            IDLE, DONE: state_nxt = can_grant ? S_A1 : IDLE;
            S_A1, S_A2, S_B0, S_B1, S_B2: begin
                if (last) begin
                    case (state)
                        S_A1:    state_nxt = S_A2;
                        S_A2:    state_nxt = S_B0;
                        S_B0:    state_nxt = S_B1;
                        S_B1:    state_nxt = S_B2;
                        default: state_nxt = DONE;
                    endcase
                end else begin
                    state_nxt = state;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        last_nxt = (cnt_nxt == CW'(STEP_CYC - 1));
        step_nxt = 1'b1;
        sa_nxt   = 2'b10;
        sf_nxt   = 2'b00;
        sc_nxt   = 3'd0;
        case (state_nxt)
            S_A1: begin sa_nxt = 2'b00; sf_nxt = 2'b01; sc_nxt = 3'd0; end
            S_A2: begin sa_nxt = 2'b01; sf_nxt = 2'b10; sc_nxt = 3'd1; end
            S_B0: begin sa_nxt = 2'b10; sf_nxt = 2'b00; sc_nxt = 3'd2; end
            S_B1: begin sa_nxt = 2'b01; sf_nxt = 2'b01; sc_nxt = 3'd3; end
            S_B2: begin sa_nxt = 2'b01; sf_nxt = 2'b10; sc_nxt = 3'd4; end
            default: step_nxt = 1'b0;
        endcase
    end

    // State, arbitration registers and outputs registered from the next state
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pend       <= '0;
            rr         <= 1'b0;
            sobrecarga <= '0;
            banco      <= 1'b0;
            sel_const  <= 3'd0;
            sel_fun    <= 2'b00;
            sel_acum   <= 2'b10;
            acum_en    <= 1'b0;
            Senal      <= 1'b0;
            Band_Listo <= 1'b0;
            ocupado    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pend       <= pend_nxt;
            sobrecarga <= sobrecarga | ovr;
            if (can_grant) begin
                banco <= gch;
                if (pend == 2'b11)
                    rr <= ~gch;
            end
            sel_const  <= sc_nxt;
            sel_fun    <= sf_nxt;
            sel_acum   <= sa_nxt;
            acum_en    <= step_nxt && last_nxt;
            Senal      <= (state_nxt == S_A2) && last_nxt;
            Band_Listo <= (state_nxt == DONE);
            ocupado    <= (state_nxt != IDLE);
        end
    end

endmodule
